// File: rtl/data_memory_unit.sv
// Data-memory stage behind memory_control: synchronous word RAM with a request handshake,
// programmable read latency and one access per instruction. Optional macro MEM_BOUNDS_CHECK_EN.
module data_memory_unit #(
    parameter int DEPTH        = 256,
    parameter int ADDR_BITS    = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        LDR,
    input  logic        STR,
    input  logic        RW,
    input  logic [31:0] address_out,
    input  logic [31:0] STR_data,
    output logic [31:0] LDR_out,
    output logic        Busy,
    output logic        Done,
    output logic        Req_err,
    output logic        Addr_err
);
    typedef enum logic [1:0] {IDLE, READ_WAIT, HOLD} state_t;

    state_t               state, state_nxt;
    logic [31:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0] idx;
    logic [3:0]           cnt;
    logic                 pend;
    logic                 rd_req, wr_req, malformed, oob;
    logic                 mem_we, rd_acc, err_acc, oob_acc, rd_done;

    assign rd_req    = LDR & ~STR & RW;
    assign wr_req    = STR & ~LDR & ~RW;
    assign malformed = (LDR & STR) | (LDR & ~RW) | (STR & RW);

`ifdef MEM_BOUNDS_CHECK_EN
    logic addr_err_q;
    logic pend_addr;
    assign oob      = |address_out[31:ADDR_BITS];
    assign Addr_err = addr_err_q;
`else
    wire unused_addr_hi = ^address_out[31:ADDR_BITS];
    assign oob      = 1'b0;
    assign Addr_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        rd_acc    = 1'b0;
        err_acc   = 1'b0;
        oob_acc   = 1'b0;
        rd_done   = 1'b0;
        case (state)
            IDLE: begin
                if (malformed) begin
                    err_acc   = 1'b1;
                    state_nxt = HOLD;
                end else if (wr_req || rd_req) begin
                    if (oob) begin
                        oob_acc   = 1'b1;
                        state_nxt = HOLD;
                    end else if (wr_req) begin
                        mem_we    = Reset;
                        state_nxt = HOLD;
                    end else begin
                        rd_acc    = 1'b1;
                        state_nxt = READ_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (cnt == 4'd0) begin
                    rd_done   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Stay parked until memory_control drops its level for this instruction.
                if (!(LDR || STR))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // RAM has no reset so it maps onto block memory; contents survive Reset.
    always_ff @(posedge Clk) begin
        if (mem_we)
            mem[address_out[ADDR_BITS-1:0]] <= STR_data;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= IDLE;
            LDR_out <= 32'd0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Req_err <= 1'b0;
            cnt     <= 4'd0;
            idx     <= '0;
            pend    <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
            addr_err_q <= 1'b0;
            pend_addr  <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            Done    <= pend;
            Req_err <= err_acc;
            pend    <= mem_we | oob_acc;
`ifdef MEM_BOUNDS_CHECK_EN
            addr_err_q <= pend_addr;
            pend_addr  <= oob_acc;
`endif
            if (rd_acc) begin
                idx  <= address_out[ADDR_BITS-1:0];
                cnt  <= 4'(READ_LATENCY - 1);
                Busy <= 1'b1;
            end else if (state == READ_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (rd_done) begin
                LDR_out <= mem[idx];
                Done    <= 1'b1;
                Busy    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_unit.sv
// Randomized bench for data_memory_unit against a timeline model of accesses.
module tb_data_memory_unit;
    localparam int L     = 2;
    localparam int AB    = 8;
    localparam int DEPTH = 256;

    logic        Clk = 1'b0, Reset = 1'b0, LDR = 1'b0, STR = 1'b0, RW = 1'b0;
    logic [31:0] address_out = '0, STR_data = '0;
    logic [31:0] LDR_out;
    logic        Busy, Done, Req_err, Addr_err;

    data_memory_unit #(.DEPTH(DEPTH), .ADDR_BITS(AB), .READ_LATENCY(L)) dut (
        .Clk(Clk), .Reset(Reset), .LDR(LDR), .STR(STR), .RW(RW),
        .address_out(address_out), .STR_data(STR_data), .LDR_out(LDR_out),
        .Busy(Busy), .Done(Done), .Req_err(Req_err), .Addr_err(Addr_err));

    always #5 Clk = ~Clk;

    int n_chk = 0, n_fail = 0, cyc_n = 0, done_seen = 0;

    // Model: a request is accepted when the unit is free; each accepted access schedules
    // its completion at an absolute cycle and frees the unit on the first idle edge after it.
    logic [31:0] m_mem [DEPTH];
    bit          eng;
    int          rel_from, wr_done_at, rd_done_at, addr_at;
    logic [AB-1:0] ridx;
    logic [31:0] e_ldr;
    bit          e_busy, e_done, e_req, e_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic bit is_oob(input logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
        return a >= DEPTH;
`else
        return 1'b0 && (a != 0);
`endif
    endfunction

    task automatic model_edge();
        if (!Reset) begin
            eng = 0; e_ldr = '0; e_busy = 0; e_done = 0; e_req = 0; e_addr = 0;
            wr_done_at = -1; rd_done_at = -1; addr_at = -1;
            return;
        end
        e_done = (wr_done_at == cyc_n);
        e_addr = (addr_at == cyc_n);
        e_req  = 0;
        if (rd_done_at == cyc_n) begin
            e_ldr = m_mem[ridx]; e_done = 1; e_busy = 0;
        end
        if (eng) begin
            if (cyc_n >= rel_from && !LDR && !STR) eng = 0;
        end else if (LDR || STR) begin
            eng = 1; rel_from = cyc_n + 1;
            if ((LDR && STR) || (LDR && !RW) || (STR && RW)) e_req = 1;
            else if (is_oob(address_out)) begin
                wr_done_at = cyc_n + 1; addr_at = cyc_n + 1;
            end else if (STR) begin
                m_mem[address_out % DEPTH] = STR_data; wr_done_at = cyc_n + 1;
            end else begin
                ridx = address_out[AB-1:0]; rd_done_at = cyc_n + L;
                rel_from = cyc_n + L + 1; e_busy = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        cyc_n++;
        model_edge();
        #1;
        done_seen += int'(Done);
        chk("LDR_out", LDR_out, e_ldr);
        chk("Busy", {31'd0, Busy}, {31'd0, e_busy});
        chk("Done", {31'd0, Done}, {31'd0, e_done});
        chk("Req_err", {31'd0, Req_err}, {31'd0, e_req});
        chk("Addr_err", {31'd0, Addr_err}, {31'd0, e_addr});
    endtask

    task automatic req(input logic ld, input logic st, input logic rw,
                       input logic [31:0] a, input logic [31:0] d, input int hold);
        LDR = ld; STR = st; RW = rw; address_out = a; STR_data = d;
        repeat (hold) step();
        LDR = 0; STR = 0;
        repeat (2) step();
    endtask

    initial begin
        int kind;
        logic [31:0] a;
        repeat (2) step();
        Reset = 1;
        step();
        for (int i = 0; i < 16; i++) req(0, 1, 0, i, $urandom, 2);

        // write then read back with latency
        req(0, 1, 0, 32'd5, 32'hDEADBEEF, 2);
        req(1, 0, 1, 32'd5, 32'd0, L + 1);
        chk("rd_after_wr", LDR_out, 32'hDEADBEEF);

        // long-held level gives one access only
        done_seen = 0;
        req(1, 0, 1, 32'd5, 32'd0, 10);
        chk("one_done", done_seen, 1);

        // malformed requests
        done_seen = 0;
        req(1, 1, 1, 32'd5, 32'h1234, 3);
        req(0, 1, 1, 32'd5, 32'h5678, 3);
        req(1, 0, 0, 32'd5, 32'h9ABC, 3);
        chk("malformed_no_done", done_seen, 0);

        // high address bits: wrap or bounds error
        req(0, 1, 0, 32'h105, 32'h11, 2);
        req(1, 0, 1, 32'd5, 32'd0, L + 1);
`ifdef MEM_BOUNDS_CHECK_EN
        chk("bounds_keep", LDR_out, 32'hDEADBEEF);
`else
        chk("wrap", LDR_out, 32'h11);
`endif

        // reset aborts an in-flight read, RAM survives
        LDR = 1; RW = 1; STR = 0; address_out = 32'd3;
        step();
        Reset = 0;
        step();
        Reset = 1; LDR = 0;
        step();
        chk("abort_ldr", LDR_out, 32'd0);
        req(1, 0, 1, 32'd3, 32'd0, L + 1);
        chk("persist", LDR_out, m_mem[3]);

        // random traffic, requests held for random spans
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                kind = $urandom_range(0, 7);
                a = $urandom_range(0, 15);
                if ($urandom_range(0, 7) == 0) a = a | ($urandom_range(1, 255) << AB);
                address_out = a; STR_data = $urandom;
                case (kind)
                    3, 4:    begin LDR = 1; STR = 0; RW = 1; end
                    5, 6:    begin LDR = 0; STR = 1; RW = 0; end
                    7:       begin LDR = 1'($urandom); STR = 1'($urandom); RW = 1'($urandom); end
                    default: begin LDR = 0; STR = 0; end
                endcase
            end
            Reset = ($urandom_range(0, 199) != 0);
            step();
        end
        Reset = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
